// File: rtl/ha_resp_checker.sv
// Half-adder response checker: golden {ca,s}=a+b compared with DUT after LATENCY cycles.
// Optional first-fail capture enabled by defining HA_CHK_FIRSTFAIL_EN.
module ha_resp_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_vectors,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_ca,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_index,
  output logic [WIDTH:0]   ff_exp,
  output logic [WIDTH:0]   ff_got
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] n_vec, acc_cnt;
  logic             start_ok, acc, last;
  logic             more, cmp_vld, hit;
  logic [WIDTH:0]   exp_now, cmp_exp, got;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign acc      = in_valid && (state == RUN);
  assign last     = acc_cnt == (n_vec - CNT_W'(1));
  assign exp_now  = {1'b0, a} + {1'b0, b};
  assign got      = {dut_ca, dut_s};
  assign hit      = cmp_exp == got;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = state == DONE;
  assign pass = done && (fail_cnt == '0);

  generate
    if (LATENCY == 0) begin : g_comb
      assign cmp_vld = acc;
      assign cmp_exp = exp_now;
      assign more    = 1'b0;
    end else begin : g_pipe
      logic [WIDTH:0]     exp_q [LATENCY];
      logic [LATENCY-1:0] vld_q;

      // Expectation delay line: golden value travels alongside the DUT latency.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= '0;
          for (int i = 0; i < LATENCY; i++) exp_q[i] <= '0;
        end else begin
          vld_q[0] <= acc;
          exp_q[0] <= exp_now;
          for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            exp_q[i] <= exp_q[i-1];
          end
        end
      end

      assign cmp_vld = vld_q[LATENCY-1];
      assign cmp_exp = exp_q[LATENCY-1];

      // Anything still in flight after this edge (the last stage compares now).
      if (LATENCY > 1) begin : g_more
        assign more = |vld_q[LATENCY-2:0];
      end else begin : g_one
        assign more = 1'b0;
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_nx = (n_vectors == '0) ? DONE : RUN;
      end
      RUN: begin
        if (acc && last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!more) state_nx = DONE;
      end
    endcase
  end

  // Run bookkeeping and saturating pass/fail counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_vec    <= '0;
      acc_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (start_ok) begin
      n_vec    <= n_vectors;
      acc_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (acc) acc_cnt <= acc_cnt + CNT_W'(1);
      if (cmp_vld) begin
        if (hit) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef HA_CHK_FIRSTFAIL_EN
  logic [CNT_W-1:0] cmp_idx;

  // First mismatch of the run is latched; later ones leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      cmp_idx  <= '0;
      ff_valid <= 1'b0;
      ff_index <= '0;
      ff_exp   <= '0;
      ff_got   <= '0;
    end else if (cmp_vld) begin
      cmp_idx <= cmp_idx + CNT_W'(1);
      if (!hit && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_index <= cmp_idx;
        ff_exp   <= cmp_exp;
        ff_got   <= got;
      end
    end
  end
`else
  assign ff_valid = 1'b0;
  assign ff_index = '0;
  assign ff_exp   = '0;
  assign ff_got   = '0;
`endif

endmodule
